// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// size/sign codes, FSM state type, byte-strobe patterns and small decode helpers.
package mem_access_unit_pkg;

   // MEM_BMC size/sign codes; 011, 110 and 111 are illegal and behave as word
   localparam logic [2:0] BMC_B  = 3'b000;
   localparam logic [2:0] BMC_H  = 3'b001;
   localparam logic [2:0] BMC_W  = 3'b010;
   localparam logic [2:0] BMC_BU = 3'b100;
   localparam logic [2:0] BMC_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // Strobe patterns for a lane-0 access, shifted up by the byte offset
   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   // Access size implied by a BMC code (illegal codes fall back to word)
   function automatic size_t bmc_size(input logic [2:0] bmc);
      size_t sz;
      case (bmc)
         BMC_B, BMC_BU: sz = SZ_BYTE;
         BMC_H, BMC_HU: sz = SZ_HALF;
         BMC_W:         sz = SZ_WORD;
         default:       sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Half on an odd byte, or word off a word boundary
   function automatic logic bmc_misaligned(input logic [2:0] bmc, input logic [1:0] off);
      logic mis;
      case (bmc_size(bmc))
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: replicates store data across lanes and
// builds strobes, and extracts/extends load data from a read word. Offsets are
// truncated (word ignores them, half keeps only bit 1) so out-of-range lanes
// can never be selected. Kept free of state so a store-to-load forwarder can
// reuse it.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  i_bmc,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   size_t       w_size;
   logic [1:0]  w_off;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic        w_signed;

   assign w_size   = bmc_size(i_bmc);
   assign w_signed = ~i_bmc[2];

   // Effective lane offset after size-dependent truncation
   always_comb begin
      w_off = 2'b00;
      case (w_size)
         SZ_BYTE: w_off = i_off;
         SZ_HALF: w_off = {i_off[1], 1'b0};
         default: w_off = 2'b00;
      endcase
   end

   // Each write lane takes the data byte it would hold for a lane-0 access
   // of the same size, which replicates bytes/halves across the word
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign o_wdata[8*gi +: 8] = (w_size == SZ_BYTE) ? i_st_data[7:0] :
                                     (w_size == SZ_HALF) ? i_st_data[8*(gi%2) +: 8] :
                                                           i_st_data[8*gi +: 8];
      end
   endgenerate

   // Byte strobes for the addressed lanes
   always_comb begin
      o_wstrb = STRB_NONE;
      case (w_size)
         SZ_BYTE: o_wstrb = STRB_B << w_off;
         SZ_HALF: o_wstrb = STRB_H << w_off;
         default: o_wstrb = STRB_W;
      endcase
   end

   assign w_ld_byte = i_ld_word[{w_off, 3'b000} +: 8];
   assign w_ld_half = w_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

   // Right-justify the addressed bytes and sign- or zero-extend them
   always_comb begin
      o_ld_data = i_ld_word;
      case (w_size)
         SZ_BYTE: o_ld_data = {{24{w_signed & w_ld_byte[7]}}, w_ld_byte};
         SZ_HALF: o_ld_data = {{16{w_signed & w_ld_half[15]}}, w_ld_half};
         default: o_ld_data = i_ld_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller. Drives a valid/grant memory port
// from the EX/MEM load/store command and stalls the pipeline until the access
// completes, so variable-latency memories are tolerated.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned half/word accesses
// skip the memory and pulse `misalign` in DONE instead of being truncated.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          MEM_MR,
   input  logic          MEM_MW,
   input  logic [2:0]    MEM_BMC,
   input  logic [31:0]   MEM_Fout,
   input  logic [DW-1:0] MEM_Data_Out,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   output logic [3:0]    dmem_wstrb,
   input  logic          dmem_gnt,
   input  logic          dmem_rvalid,
   input  logic [DW-1:0] dmem_rdata,
   output logic          stall,
   output logic [DW-1:0] load_data,
   output logic          load_valid,
   output logic          misalign
);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_load_data;

   logic        w_cmd;
   logic        w_is_store;
   logic        w_is_load;
   logic        w_in_req;
   logic        w_capture;
   logic        w_trap;      // command must be trapped instead of issued
   logic        w_trapped;   // current DONE is the result of a trap
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_ld_ext;

   // Store takes priority when both command bits are set
   assign w_cmd      = MEM_MR | MEM_MW;
   assign w_is_store = MEM_MW;
   assign w_is_load  = MEM_MR & ~MEM_MW;
   assign w_in_req   = (r_state == ST_REQ);

   mem_lane_align u_align (
      .i_bmc     (MEM_BMC),
      .i_off     (MEM_Fout[1:0]),
      .i_st_data (MEM_Data_Out),
      .o_wdata   (w_wdata),
      .o_wstrb   (w_wstrb),
      .i_ld_word (dmem_rdata),
      .o_ld_data (w_ld_ext)
   );

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_trap    = bmc_misaligned(MEM_BMC, MEM_Fout[1:0]);
   assign w_trapped = r_misalign;
   assign misalign  = (r_state == ST_DONE) & r_misalign;

   // Remember whether the access leaving IDLE was trapped
   always_ff @(posedge clk) begin
      if (rst)
         r_misalign <= 1'b0;
      else if (r_state == ST_IDLE)
         r_misalign <= w_cmd & w_trap;
   end
`else
   assign w_trap    = 1'b0;
   assign w_trapped = 1'b0;
   assign misalign  = 1'b0;
`endif

   // Read data is accepted only in WAIT, or in REQ when it rides on the grant
   assign w_capture = w_is_load & dmem_rvalid &
                      ((w_in_req & dmem_gnt) | (r_state == ST_WAIT));

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd)
               w_state_next = w_trap ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            if (dmem_gnt) begin
               if (w_is_store || w_capture)
                  w_state_next = ST_DONE;
               else
                  w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_capture)
               w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register and captured load result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_load_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture)
            r_load_data <= w_ld_ext;
      end
   end

   // Request outputs come straight from the held inputs, so they stay stable
   // for as long as the request waits for a grant
   assign dmem_req   = w_in_req;
   assign dmem_we    = w_in_req & w_is_store;
   assign dmem_addr  = {MEM_Fout[AW-1:2], 2'b00};
   assign dmem_wdata = w_wdata;
   assign dmem_wstrb = w_in_req ? w_wstrb : STRB_NONE;

   assign stall      = (r_state != ST_DONE) & w_cmd;
   assign load_data  = r_load_data;
   assign load_valid = (r_state == ST_DONE) & w_is_load & ~w_trapped;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses against a byte-level reference model of the alignment rules.
`timescale 1ns/1ps
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mr, mw;
   logic [2:0]  bmc;
   logic [31:0] fout, dout;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        gnt, rvalid;
   logic [31:0] rdata;
   logic        stall, load_valid, misalign;
   logic [31:0] load_data;

   int n_vec = 0;
   int n_err = 0;

   // Observations of the last access
   int          o_cycles, o_stalls, o_reqs, o_lv_cnt, o_mis_cnt;
   bit          o_done, o_unstable, o_we;
   logic [31:0] o_addr, o_wdata, o_ld;
   logic [3:0]  o_wstrb;

   always #5 clk = ~clk;

   mem_access_unit #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .MEM_MR(mr), .MEM_MW(mw), .MEM_BMC(bmc), .MEM_Fout(fout), .MEM_Data_Out(dout),
      .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_wstrb(wstrb),
      .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid), .misalign(misalign)
   );

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] c);
      if (c == 3'b000 || c == 3'b100) return 1;
      if (c == 3'b001 || c == 3'b101) return 2;
      return 4;
   endfunction

   function automatic int m_off(input int sz, input logic [1:0] off);
      if (sz == 1) return int'(off);
      if (sz == 2) return int'(off & 2'd2);
      return 0;
   endfunction

   function automatic bit m_trap(input int sz, input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
      return (sz == 2 && off[0]) || (sz == 4 && off != 2'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_wstrb(input int sz, input int eo);
      logic [3:0] r = '0;
      for (int k = 0; k < 4; k++) r[k] = (k >= eo) && (k < eo + sz);
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'((d >> (8 * (k % sz))) & 32'hFF);
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] c, input logic [1:0] off,
                                          input logic [31:0] rd);
      int     sz = m_size(c);
      int     eo = m_off(sz, off);
      longint v  = 0;
      for (int i = 0; i < sz; i++)
         v += longint'((rd >> (8 * (eo + i))) & 32'hFF) << (8 * i);
      if (sz < 4 && c[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1)))
         v -= (longint'(1) << (8 * sz));
      return v[31:0];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mr = 0; mw = 0; gnt = 0; rvalid = 0;
      end
   endtask

   // Present one command and act as memory: grant in REQ cycle gpos, return
   // read data rdel cycles after the grant; spurious rvalid before the grant.
   task automatic run_access(input logic a_mr, input logic a_mw, input logic [2:0] a_bmc,
                             input logic [31:0] a_fout, input logic [31:0] a_data,
                             input int gpos, input int rdel, input logic [31:0] a_rdata);
      int cyc  = 0;
      int gcyc = -1;
      bit is_load = a_mr & ~a_mw;
      o_cycles = 0; o_stalls = 0; o_reqs = 0; o_lv_cnt = 0; o_mis_cnt = 0;
      o_done = 0; o_unstable = 0; o_we = 0; o_addr = '0; o_wdata = '0; o_wstrb = '0; o_ld = '0;
      while (!o_done && cyc < 40) begin
         @(negedge clk);
         if (cyc == 0) begin
            mr = a_mr; mw = a_mw; bmc = a_bmc; fout = a_fout; dout = a_data;
         end
         gnt = 0; rvalid = 0; rdata = $urandom;
         #1;
         cyc++;
         if (stall) o_stalls++;
         if (load_valid) o_lv_cnt++;
         if (misalign) o_mis_cnt++;
         if (req) begin
            o_reqs++;
            if (o_reqs == 1) begin
               o_addr = addr; o_wdata = wdata; o_wstrb = wstrb; o_we = we;
            end else if (addr !== o_addr || wdata !== o_wdata || wstrb !== o_wstrb || we !== o_we)
               o_unstable = 1;
            if (o_reqs == gpos) begin gnt = 1; gcyc = cyc; end
         end
         if (gcyc >= 0 && is_load && cyc == gcyc + rdel) begin
            rvalid = 1; rdata = a_rdata;
         end else if (gcyc < 0 && $urandom_range(0, 1) == 1)
            rvalid = 1;
         if (!stall) begin o_done = 1; o_ld = load_data; end
      end
      o_cycles = cyc;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; mr = 0; mw = 0; bmc = 0; fout = 0; dout = 0; gnt = 0; rvalid = 0; rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", req); end
      n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", we); end
      n_vec++; if (wstrb !== 4'b0) begin n_err++; $display("FAIL reset_wstrb got %b want 0000", wstrb); end
      n_vec++; if (load_data !== 32'h0) begin n_err++; $display("FAIL reset_load_data got %h want 0", load_data); end
      n_vec++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL reset_load_valid got %b want 0", load_valid); end
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", misalign); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
      rst = 0;
      $display("reset checked");
   endtask

   task automatic test_store_byte();
      run_access(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 1, 0, 32'h0);
      $display("store byte: cycles=%0d stalls=%0d addr=%h wstrb=%b wdata=%h", o_cycles, o_stalls, o_addr, o_wstrb, o_wdata);
      n_vec++; if (o_reqs != 1) begin n_err++; $display("FAIL sb_reqs got %0d want 1", o_reqs); end
      n_vec++; if (o_addr !== 32'h1000) begin n_err++; $display("FAIL sb_addr got %h want 00001000", o_addr); end
      n_vec++; if (o_wstrb !== 4'b1000) begin n_err++; $display("FAIL sb_wstrb got %b want 1000", o_wstrb); end
      n_vec++; if (o_wdata !== 32'hABABABAB) begin n_err++; $display("FAIL sb_wdata got %h want abababab", o_wdata); end
      n_vec++; if (o_we !== 1'b1) begin n_err++; $display("FAIL sb_we got %b want 1", o_we); end
      n_vec++; if (o_stalls != 2 || o_cycles != 3) begin n_err++; $display("FAIL sb_timing got stalls=%0d cycles=%0d want 2/3", o_stalls, o_cycles); end
      n_vec++; if (o_lv_cnt != 0) begin n_err++; $display("FAIL sb_load_valid got %0d pulses want 0", o_lv_cnt); end
   endtask

   task automatic test_load_byte();
      run_access(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 1, 1, 32'h12348056);
      $display("load byte signed: ld=%h lv=%0d stalls=%0d", o_ld, o_lv_cnt, o_stalls);
      n_vec++; if (o_ld !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", o_ld); end
      n_vec++; if (o_lv_cnt != 1) begin n_err++; $display("FAIL lb_valid got %0d pulses want 1", o_lv_cnt); end
      n_vec++; if (o_stalls != 3 || o_cycles != 4) begin n_err++; $display("FAIL lb_timing got stalls=%0d cycles=%0d want 3/4", o_stalls, o_cycles); end
      n_vec++; if (o_we !== 1'b0 || o_addr !== 32'h2000) begin n_err++; $display("FAIL lb_req got we=%b addr=%h want 0/00002000", o_we, o_addr); end
      idle(1);
      run_access(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 1, 1, 32'h12348056);
      $display("load byte unsigned: ld=%h lv=%0d", o_ld, o_lv_cnt);
      n_vec++; if (o_ld !== 32'h00000080) begin n_err++; $display("FAIL lbu_data got %h want 00000080", o_ld); end
      n_vec++; if (o_lv_cnt != 1) begin n_err++; $display("FAIL lbu_valid got %0d pulses want 1", o_lv_cnt); end
      idle(1);
   endtask

   task automatic test_load_half_delay();
      run_access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 3, 2, 32'hBEEF0000);
      $display("load half delayed: reqs=%0d addr=%h ld=%h stalls=%0d", o_reqs, o_addr, o_ld, o_stalls);
      n_vec++; if (o_reqs != 3) begin n_err++; $display("FAIL lh_reqs got %0d want 3", o_reqs); end
      n_vec++; if (o_unstable || o_addr !== 32'h2000) begin n_err++; $display("FAIL lh_addr got %h unstable=%b want 00002000 stable", o_addr, o_unstable); end
      n_vec++; if (o_ld !== 32'hFFFFBEEF) begin n_err++; $display("FAIL lh_data got %h want ffffbeef", o_ld); end
      n_vec++; if (o_stalls != 6) begin n_err++; $display("FAIL lh_stall got %0d want 6", o_stalls); end
      idle(1);
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 1, 0, 32'h0);
      $display("b2b store: reqs=%0d cycles=%0d wstrb=%b", o_reqs, o_cycles, o_wstrb);
      n_vec++; if (o_reqs != 1 || o_cycles != 3 || o_wstrb !== 4'b1111) begin n_err++; $display("FAIL b2b_store got reqs=%0d cycles=%0d wstrb=%b want 1/3/1111", o_reqs, o_cycles, o_wstrb); end
      run_access(1'b1, 1'b0, 3'b101, 32'h0000_0046, 32'h0, 1, 1, 32'h9876_5432);
      $display("b2b load: reqs=%0d cycles=%0d stalls=%0d ld=%h", o_reqs, o_cycles, o_stalls, o_ld);
      n_vec++; if (o_reqs != 1 || o_cycles != 4 || o_stalls != 3) begin n_err++; $display("FAIL b2b_load got reqs=%0d cycles=%0d stalls=%0d want 1/4/3", o_reqs, o_cycles, o_stalls); end
      n_vec++; if (o_ld !== 32'h0000_9876) begin n_err++; $display("FAIL b2b_data got %h want 00009876", o_ld); end
      idle(1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk); mr = 1; mw = 0; bmc = 3'b010; fout = 32'h500; gnt = 0; rvalid = 0; #1;
      @(negedge clk); gnt = 1; #1;
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rm_req got %b want 1", req); end
      @(negedge clk); gnt = 0; rst = 1; #1;
      @(negedge clk); rst = 0; mr = 0; rvalid = 1; rdata = 32'hDEADBEEF; #1;
      n_vec++; if (stall !== 1'b0 || req !== 1'b0) begin n_err++; $display("FAIL rm_idle got stall=%b req=%b want 0/0", stall, req); end
      n_vec++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL rm_lv got %b want 0", load_valid); end
      @(negedge clk); rvalid = 0; #1;
      n_vec++; if (load_valid !== 1'b0 || load_data !== 32'h0) begin n_err++; $display("FAIL rm_late got lv=%b data=%h want 0/0", load_valid, load_data); end
      run_access(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 1, 1, 32'hA5A5_0F0F);
      $display("reset mid-access then load: ld=%h cycles=%0d", o_ld, o_cycles);
      n_vec++; if (o_ld !== 32'hA5A5_0F0F || o_cycles != 4) begin n_err++; $display("FAIL rm_recover got %h/%0d want a5a50f0f/4", o_ld, o_cycles); end
      idle(1);
   endtask

   task automatic test_misalign();
      run_access(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 1, 1, 32'hCAFE_F00D);
      $display("word load at 3002: reqs=%0d mis=%0d stalls=%0d ld=%h", o_reqs, o_mis_cnt, o_stalls, o_ld);
`ifdef MISALIGN_TRAP_EN
      n_vec++; if (o_reqs != 0) begin n_err++; $display("FAIL ma_req got %0d want 0", o_reqs); end
      n_vec++; if (o_mis_cnt != 1 || o_lv_cnt != 0) begin n_err++; $display("FAIL ma_flag got mis=%0d lv=%0d want 1/0", o_mis_cnt, o_lv_cnt); end
      n_vec++; if (o_stalls != 1 || o_cycles != 2) begin n_err++; $display("FAIL ma_timing got stalls=%0d cycles=%0d want 1/2", o_stalls, o_cycles); end
      run_access(1'b0, 1'b1, 3'b001, 32'h3001, 32'h1234, 1, 0, 32'h0);
      n_vec++; if (o_reqs != 0 || o_mis_cnt != 1) begin n_err++; $display("FAIL ma_store got reqs=%0d mis=%0d want 0/1", o_reqs, o_mis_cnt); end
`else
      n_vec++; if (o_reqs != 1 || o_addr !== 32'h3000) begin n_err++; $display("FAIL ma_trunc got reqs=%0d addr=%h want 1/00003000", o_reqs, o_addr); end
      n_vec++; if (o_ld !== 32'hCAFE_F00D || o_mis_cnt != 0) begin n_err++; $display("FAIL ma_data got %h mis=%0d want cafef00d/0", o_ld, o_mis_cnt); end
`endif
      idle(1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         logic [2:0]  c    = 3'($urandom_range(0, 7));
         logic [31:0] fa   = $urandom;
         logic [31:0] d    = $urandom;
         logic [31:0] rd   = $urandom;
         int          kind = $urandom_range(0, 2);
         int          gp   = $urandom_range(1, 3);
         int          rdl  = $urandom_range(0, 2);
         int          nidl = $urandom_range(0, 2);
         logic        a_mr = (kind != 0);
         logic        a_mw = (kind != 1);
         bit          ld   = a_mr & ~a_mw;
         int          sz   = m_size(c);
         int          eo   = m_off(sz, fa[1:0]);
         bit          trap = m_trap(sz, fa[1:0]);
         int          e_cyc = trap ? 2 : (ld ? 2 + gp + rdl : 2 + gp);
         for (int i = 0; i < nidl; i++) begin
            idle(1); #1;
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rnd_idle_stall got %b want 0", stall); end
         end
         run_access(a_mr, a_mw, c, fa, d, gp, rdl, rd);
         $display("rnd %0d: mr=%b mw=%b bmc=%b fout=%h gnt@%0d rv+%0d -> cyc=%0d reqs=%0d wstrb=%b ld=%h",
                  t, a_mr, a_mw, c, fa, gp, rdl, o_cycles, o_reqs, o_wstrb, o_ld);
         n_vec++; if (!o_done || o_cycles != e_cyc || o_stalls != e_cyc - 1) begin n_err++; $display("FAIL rnd_timing got cyc=%0d stalls=%0d want %0d/%0d", o_cycles, o_stalls, e_cyc, e_cyc - 1); end
         n_vec++; if (o_reqs != (trap ? 0 : gp) || o_unstable) begin n_err++; $display("FAIL rnd_req got reqs=%0d unstable=%b want %0d stable", o_reqs, o_unstable, trap ? 0 : gp); end
         n_vec++; if (o_mis_cnt != int'(trap)) begin n_err++; $display("FAIL rnd_misalign got %0d want %0d", o_mis_cnt, int'(trap)); end
         n_vec++; if (o_lv_cnt != int'(ld && !trap)) begin n_err++; $display("FAIL rnd_load_valid got %0d want %0d", o_lv_cnt, int'(ld && !trap)); end
         if (!trap) begin
            n_vec++; if (o_addr !== {fa[31:2], 2'b00} || o_we !== bit'(!ld)) begin n_err++; $display("FAIL rnd_addr got %h we=%b want %h we=%b", o_addr, o_we, {fa[31:2], 2'b00}, !ld); end
            if (ld) begin
               n_vec++; if (o_ld !== m_load(c, fa[1:0], rd)) begin n_err++; $display("FAIL rnd_load got %h want %h", o_ld, m_load(c, fa[1:0], rd)); end
            end else begin
               n_vec++; if (o_wstrb !== m_wstrb(sz, eo)) begin n_err++; $display("FAIL rnd_wstrb got %b want %b", o_wstrb, m_wstrb(sz, eo)); end
               n_vec++; if (o_wdata !== m_wdata(sz, d)) begin n_err++; $display("FAIL rnd_wdata got %h want %h", o_wdata, m_wdata(sz, d)); end
            end
         end
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_byte();
      test_load_half_delay();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish by 500000 ns");
      $fatal(1, "watchdog");
   end

endmodule
